// File: rtl/soundweb_pkg.sv
// Shared constants and helpers for the Soundweb direct-inject byte protocol.
// Used by both the receive path here and the transmit-side encoder.
package soundweb_pkg;

    localparam logic [7:0] STX        = 8'h02;
    localparam logic [7:0] ETX        = 8'h03;
    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam logic [7:0] ESC        = 8'h1B;
    localparam logic [7:0] ESC_OFFSET = 8'h80;

    localparam int BODY_BYTES = 14;

    // Position of each un-stuffed byte inside the frame body
    localparam int CMD      = 0;
    localparam int ADDR0    = 1;
    localparam int ADDR1    = 2;
    localparam int ADDR2    = 3;
    localparam int ADDR3    = 4;
    localparam int ADDR4    = 5;
    localparam int ADDR5    = 6;
    localparam int SV0      = 7;
    localparam int SV1      = 8;
    localparam int DATA0    = 9;
    localparam int DATA1    = 10;
    localparam int DATA2    = 11;
    localparam int DATA3    = 12;
    localparam int CHECKSUM = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BODY,
        ST_ESCAPE
    } rx_state_t;

    function automatic logic is_reserved_byte(input logic [7:0] b);
        return (b == STX) || (b == ETX) || (b == ACK) || (b == NAK) || (b == ESC);
    endfunction

endpackage

// File: rtl/soundweb_unstuffer.sv
// Framing FSM: finds STX/ETX boundaries, removes ESC stuffing and reports
// per-byte strobes to the frame assembler. All strobes are combinational.
module soundweb_unstuffer
    import soundweb_pkg::*;
#(
    parameter bit STRICT_ESCAPE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_full,
    output logic       byte_strobe,
    output logic [7:0] byte_value,
    output logic       sof,
    output logic       eof,
    output logic       err,
    output logic       ack,
    output logic       nak
);

    rx_state_t  state_reg;
    rx_state_t  state_next;
    logic [7:0] decoded;

    assign decoded = rx_data - ESC_OFFSET;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        byte_strobe = 1'b0;
        byte_value  = rx_data;
        sof         = 1'b0;
        eof         = 1'b0;
        err         = 1'b0;
        ack         = 1'b0;
        nak         = 1'b0;
        if (rx_valid) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (rx_data == STX) begin
                        sof        = 1'b1;
                        state_next = ST_BODY;
                    end else if (rx_data == ACK) begin
                        ack = 1'b1;
                    end else if (rx_data == NAK) begin
                        nak = 1'b1;
                    end
                end
                ST_BODY: begin
                    if (rx_data == STX) begin
                        sof = 1'b1;
                    end else if (rx_data == ESC) begin
                        state_next = ST_ESCAPE;
                    end else if (rx_data == ETX) begin
                        eof        = 1'b1;
                        state_next = ST_IDLE;
                    end else if (rx_data == ACK || rx_data == NAK || frame_full) begin
                        err        = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        byte_strobe = 1'b1;
                    end
                end
                ST_ESCAPE: begin
                    if (rx_data == STX) begin
                        sof        = 1'b1;
                        state_next = ST_BODY;
                    end else if (rx_data == ETX || frame_full ||
                                 (STRICT_ESCAPE && !is_reserved_byte(decoded))) begin
                        err        = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        byte_strobe = 1'b1;
                        byte_value  = decoded;
                        state_next  = ST_BODY;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/soundweb_decoder.sv
// Soundweb receive decoder: assembles un-stuffed frame bytes, checks the XOR
// checksum and commits good frames to the registered output fields.
module soundweb_decoder
    import soundweb_pkg::*;
#(
    parameter bit STRICT_ESCAPE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] command,
    output logic [7:0] address_0,
    output logic [7:0] address_1,
    output logic [7:0] address_2,
    output logic [7:0] address_3,
    output logic [7:0] address_4,
    output logic [7:0] address_5,
    output logic [7:0] sv_0,
    output logic [7:0] sv_1,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    output logic       packet_valid,
    output logic       checksum_error,
    output logic       frame_error,
    output logic       ack_seen,
    output logic       nak_seen
);

    logic       byte_strobe;
    logic [7:0] byte_value;
    logic       sof;
    logic       eof;
    logic       err;
    logic       ack;
    logic       nak;
    logic       frame_full;
    logic       commit;

    logic [3:0] count_reg;
    logic [7:0] xor_reg;
    logic [7:0] field_q [CHECKSUM];

    soundweb_unstuffer #(
        .STRICT_ESCAPE(STRICT_ESCAPE)
    ) u_unstuffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_full (frame_full),
        .byte_strobe(byte_strobe),
        .byte_value (byte_value),
        .sof        (sof),
        .eof        (eof),
        .err        (err),
        .ack        (ack),
        .nak        (nak)
    );

    assign frame_full = (count_reg == 4'(BODY_BYTES));
    // XOR over all 14 bytes, checksum included, cancels to zero on a good frame
    assign commit     = eof && frame_full && (xor_reg == 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg      <= 4'd0;
            xor_reg        <= 8'h00;
            packet_valid   <= 1'b0;
            checksum_error <= 1'b0;
            frame_error    <= 1'b0;
            ack_seen       <= 1'b0;
            nak_seen       <= 1'b0;
        end else begin
            packet_valid   <= commit;
            checksum_error <= eof && frame_full && (xor_reg != 8'h00);
            frame_error    <= err || (eof && !frame_full);
            ack_seen       <= ack;
            nak_seen       <= nak;
            if (sof) begin
                count_reg <= 4'd0;
                xor_reg   <= 8'h00;
            end else if (byte_strobe) begin
                count_reg <= count_reg + 4'd1;
                xor_reg   <= xor_reg ^ byte_value;
            end
        end
    end

    // The checksum byte only feeds the XOR, so shadows cover fields 0..12
    genvar gi;
    generate
        for (gi = 0; gi < CHECKSUM; gi++) begin : gen_field
            logic [7:0] shadow_reg;
            logic [7:0] field_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    shadow_reg <= 8'h00;
                    field_reg  <= 8'h00;
                end else begin
                    if (byte_strobe && count_reg == 4'(gi)) begin
                        shadow_reg <= byte_value;
                    end
                    if (commit) begin
                        field_reg <= shadow_reg;
                    end
                end
            end

            assign field_q[gi] = field_reg;
        end
    endgenerate

    assign command   = field_q[CMD];
    assign address_0 = field_q[ADDR0];
    assign address_1 = field_q[ADDR1];
    assign address_2 = field_q[ADDR2];
    assign address_3 = field_q[ADDR3];
    assign address_4 = field_q[ADDR4];
    assign address_5 = field_q[ADDR5];
    assign sv_0      = field_q[SV0];
    assign sv_1      = field_q[SV1];
    assign data_0    = field_q[DATA0];
    assign data_1    = field_q[DATA1];
    assign data_2    = field_q[DATA2];
    assign data_3    = field_q[DATA3];

endmodule

// File: tb/tb_soundweb_decoder.sv
// Scoreboard bench for soundweb_decoder: the driver queues expected status
// events, a negedge monitor pops and compares them as the DUT pulses.
module tb_soundweb_decoder;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [4:0]   kind;
        logic [103:0] fields;
        int           cyc;
    } exp_t;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_PKT  = 5'b10000;
    localparam logic [4:0] K_CSUM = 5'b01000;
    localparam logic [4:0] K_FERR = 5'b00100;
    localparam logic [4:0] K_ACK  = 5'b00010;
    localparam logic [4:0] K_NAK  = 5'b00001;

    localparam logic [103:0] F1 = {8'h88, 8'h00, 8'h10, 8'h03, 8'h00, 8'h01, 8'h00,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    localparam logic [103:0] F2 = {8'h11, 8'h22, 88'h0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] command, address_0, address_1, address_2, address_3, address_4, address_5;
    logic [7:0] sv_0, sv_1, data_0, data_1, data_2, data_3;
    logic       packet_valid, checksum_error, frame_error, ack_seen, nak_seen;

    int           cyc = 0;
    int           n_compared = 0;
    int           n_mismatched = 0;
    exp_t         sb_q[$];
    logic [103:0] model_fields = 104'h0;

    wire [103:0] fields_now = {command, address_0, address_1, address_2, address_3,
                               address_4, address_5, sv_0, sv_1,
                               data_0, data_1, data_2, data_3};
    wire [4:0]   pulses = {packet_valid, checksum_error, frame_error, ack_seen, nak_seen};

    soundweb_decoder #(
        .STRICT_ESCAPE(1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .command       (command),
        .address_0     (address_0),
        .address_1     (address_1),
        .address_2     (address_2),
        .address_3     (address_3),
        .address_4     (address_4),
        .address_5     (address_5),
        .sv_0          (sv_0),
        .sv_1          (sv_1),
        .data_0        (data_0),
        .data_1        (data_1),
        .data_2        (data_2),
        .data_3        (data_3),
        .packet_valid  (packet_valid),
        .checksum_error(checksum_error),
        .frame_error   (frame_error),
        .ack_seen      (ack_seen),
        .nak_seen      (nak_seen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every status pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1 && pulses !== 5'b0) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", 128'(pulses), 128'(K_NONE));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("pulse_kind", 128'(pulses), 128'(e.kind));
                check("pulse_latency", 128'(cyc), 128'(e.cyc));
                check("fields", 128'(fields_now), 128'(e.fields));
                $display("event kind=%05b cycle=%0d fields=%026h", pulses, cyc, fields_now);
            end
        end
    end

    // Byte is sampled at the next posedge; its pulse is visible one cycle later
    task automatic send(input logic [7:0] b, input logic [4:0] kind);
        exp_t e;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        if (kind != K_NONE) begin
            e.kind   = kind;
            e.fields = model_fields;
            e.cyc    = cyc + 1;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input string name, input byte_q_t q, input int trig,
                              input logic [4:0] kind, input logic [103:0] new_fields,
                              input bit gap);
        for (int i = 0; i < q.size(); i++) begin
            if (i == trig && kind == K_PKT) model_fields = new_fields;
            send(q[i], (i == trig) ? kind : K_NONE);
            if (gap) idle(1);
        end
        idle(4);
        check({name, "_drain"}, 128'(sb_q.size()), 128'(0));
        $display("frame %s: %0d bytes sent", name, q.size());
    endtask

    initial begin
        byte_q_t g, g_bad, f2, q;

        g     = '{8'h02, 8'h88, 8'h00, 8'h10, 8'h1B, 8'h83, 8'h00, 8'h01, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h9B, 8'h03};
        g_bad = g;
        g_bad[15] = 8'h9C;
        f2    = '{8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h03};

        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_fields", 128'(fields_now), 128'(0));
        check("reset_pulses", 128'(pulses), 128'(0));
        rst_n = 1'b1;
        idle(2);

        send_frame("good", g, 16, K_PKT, F1, 1'b0);

        q = '{8'h02, 8'h88, 8'h00, 8'h10, 8'h1B, 8'h10, 8'h03, 8'h55, 8'h66};
        send_frame("strict_escape", q, 5, K_FERR, F1, 1'b0);
        send_frame("good_f2", f2, 15, K_PKT, F2, 1'b0);

        send_frame("bad_checksum", g_bad, 16, K_CSUM, F2, 1'b0);

        q = '{8'h02, 8'h88, 8'h00};
        q = {q, g};
        send_frame("restart", q, 19, K_PKT, F1, 1'b0);

        send(8'h06, K_ACK);
        send(8'h15, K_NAK);
        send(8'h03, K_NONE);
        send(8'h55, K_NONE);
        idle(4);
        check("ack_nak_drain", 128'(sb_q.size()), 128'(0));

        q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
        send_frame("overlong", q, 15, K_FERR, F1, 1'b0);
        q = '{8'h02, 8'h88, 8'h1B, 8'h03};
        send_frame("esc_etx", q, 3, K_FERR, F1, 1'b0);
        q = '{8'h02, 8'h88, 8'h06};
        send_frame("raw_ack_in_body", q, 2, K_FERR, F1, 1'b0);
        q = '{8'h02, 8'h88, 8'h00, 8'h03};
        send_frame("short", q, 3, K_FERR, F1, 1'b0);

        send_frame("f2_again", f2, 15, K_PKT, F2, 1'b0);
        send_frame("toggle_valid", g, 16, K_PKT, F1, 1'b1);

        // Reset mid-frame: partial frame discarded, remainder ignored
        for (int i = 0; i < 9; i++) send(g[i], K_NONE);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        model_fields = 104'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 9; i < g.size(); i++) send(g[i], K_NONE);
        idle(4);
        check("mid_reset_fields", 128'(fields_now), 128'(0));
        check("mid_reset_drain", 128'(sb_q.size()), 128'(0));
        $display("frame mid_reset: %0d bytes sent", g.size());

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
